// File: rtl/mem_seq_engine.sv
// mem_seq_engine: start/busy/done sequencer for load, store, fill and copy over a 16x4 memory (optional MEM_SEQ_CHECKSUM_EN)
module mem_seq_engine #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_SEQ_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3;
    localparam logic [1:0] OP_LOAD = 2'd0, OP_STORE = 2'd1, OP_FILL = 2'd2, OP_COPY = 2'd3;
    localparam logic [ADDR_W-1:0] ONE = 1;
    logic [1:0]        state, op_r, first_st;
    logic [ADDR_W-1:0] src_r, dst_r, len_r, idx, idx_nxt;
    logic [DATA_W-1:0] wd_r, hold;
    logic              accept;
    // outputs decoded purely from registered state so they never glitch within a cycle
    always_comb begin
        busy        = (state == RD) || (state == WR);
        done        = state == FIN;
        mem_write   = state == WR;
        mem_address = (state == RD) ? src_r + idx : (state == WR) ? dst_r + idx : '0;
        mem_wdata   = (state == WR) ? ((op_r == OP_COPY) ? hold : wd_r) : '0;
        accept      = start && !busy;
        idx_nxt     = idx + ONE;
        first_st    = (op == OP_LOAD) ? RD : (op == OP_STORE) ? WR : (length == '0) ? FIN : (op == OP_FILL) ? WR : RD;
    end
    // operand latch and RD/WR sequencing; a start is only taken from IDLE or FIN
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_r      <= OP_LOAD;
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= '0;
            wd_r      <= '0;
            idx       <= '0;
            hold      <= '0;
            load_data <= '0;
        end else if (accept) begin
            op_r  <= op;
            src_r <= src_addr;
            dst_r <= dst_addr;
            len_r <= length;
            wd_r  <= wr_data;
            idx   <= '0;
            state <= first_st;
        end else begin
            case (state)
                RD: begin
                    hold <= mem_rdata;
                    if (op_r == OP_LOAD) load_data <= mem_rdata;
                    state <= (op_r == OP_LOAD) ? FIN : WR;
                end
                WR: begin
                    idx   <= idx_nxt;
                    state <= (op_r == OP_STORE || idx_nxt == len_r) ? FIN : (op_r == OP_FILL) ? WR : RD;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef MEM_SEQ_CHECKSUM_EN
    // running modular sum of every nibble written by the current operation
    always_ff @(posedge clk) begin
        if (reset || accept) checksum <= '0;
        else if (state == WR) checksum <= checksum + mem_wdata;
    end
`endif
endmodule

// File: tb/tb_mem_seq_engine.sv
// tb_mem_seq_engine: directed and random operations checked against an operation-level memory model
module tb_mem_seq_engine;
    logic       clk = 0, reset = 1, start = 0;
    logic [1:0] op_i = 0;
    logic [3:0] src_i = 0, dst_i = 0, len_i = 0, wd_i = 0;
    logic       busy, done, mem_write;
    logic [3:0] load_data, mem_address, mem_wdata, mem_rdata;
`ifdef MEM_SEQ_CHECKSUM_EN
    logic [3:0] checksum;
`endif
    logic [3:0] mem [16];
    logic [3:0] ref_mem [16];
    logic [3:0] exp_load = 0;
    logic [1:0] nxt_op;
    logic [3:0] nxt_src, nxt_dst, nxt_len, nxt_wd;
    int n_cmp = 0, n_bad = 0;

    mem_seq_engine dut (
        .clk(clk), .reset(reset), .start(start), .op(op_i), .src_addr(src_i), .dst_addr(dst_i),
        .length(len_i), .wr_data(wd_i), .busy(busy), .done(done), .load_data(load_data),
        .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_SEQ_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) for (int i = 0; i < 16; i++) mem[i] <= 4'd0;
        else if (mem_write) mem[mem_address] <= mem_wdata;
    end
    assign mem_rdata = mem_write ? 4'd0 : mem[mem_address];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected per-cycle port activity derived from the operation semantics, then compared cycle by cycle
    task automatic run(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                       input logic [3:0] len, input logic [3:0] wd, input bit pre, input bit chain, input bit junk);
        logic [7:0] ea[$], ew[$], ed[$];
        logic [3:0] ck = 0, a, d, v;
        case (op)
            2'd0: begin ea.push_back(8'(src)); ew.push_back(0); ed.push_back(0); exp_load = ref_mem[src]; end
            2'd1: begin ea.push_back(8'(dst)); ew.push_back(1); ed.push_back(8'(wd)); ref_mem[dst] = wd; ck = wd; end
            2'd2: for (int i = 0; i < int'(len); i++) begin
                a = dst + 4'(i);
                ea.push_back(8'(a)); ew.push_back(1); ed.push_back(8'(wd));
                ref_mem[a] = wd; ck = ck + wd;
            end
            default: for (int i = 0; i < int'(len); i++) begin
                a = src + 4'(i); d = dst + 4'(i); v = ref_mem[a];
                ea.push_back(8'(a)); ew.push_back(0); ed.push_back(0);
                ea.push_back(8'(d)); ew.push_back(1); ed.push_back(8'(v));
                ref_mem[d] = v; ck = ck + v;
            end
        endcase
        if (!pre) begin
            @(negedge clk);
            op_i = op; src_i = src; dst_i = dst; len_i = len; wd_i = wd; start = 1;
        end
        for (int k = 0; k < ea.size(); k++) begin
            @(negedge clk);
            start = junk && k == 1;
            if (junk && k == 1) begin
                op_i = 2'($urandom); src_i = 4'($urandom); dst_i = dst + 4'd7; len_i = 4'd15; wd_i = ~wd;
            end
            chk("busy", 8'(busy), 8'd1);
            chk("done_early", 8'(done), 8'd0);
            chk("addr", 8'(mem_address), ea[k]);
            chk("write", 8'(mem_write), ew[k]);
            if (ew[k] == 8'd1) chk("wdata", 8'(mem_wdata), ed[k]);
        end
        @(negedge clk);
        chk("done", 8'(done), 8'd1);
        chk("busy_fin", 8'(busy), 8'd0);
        chk("write_fin", 8'(mem_write), 8'd0);
        chk("addr_fin", 8'(mem_address), 8'd0);
        chk("wdata_fin", 8'(mem_wdata), 8'd0);
        chk("load_data", 8'(load_data), 8'(exp_load));
`ifdef MEM_SEQ_CHECKSUM_EN
        chk("checksum", 8'(checksum), 8'(ck));
`endif
        if (chain) begin
            op_i = nxt_op; src_i = nxt_src; dst_i = nxt_dst; len_i = nxt_len; wd_i = nxt_wd; start = 1;
        end else start = 0;
    endtask

    initial begin
        logic [1:0] c_op;
        logic [3:0] c_src, c_dst, c_len, c_wd;
        bit pre, ch;
        for (int i = 0; i < 16; i++) ref_mem[i] = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_load", 8'(load_data), 8'd0);
        chk("rst_addr", 8'(mem_address), 8'd0);
        chk("rst_write", 8'(mem_write), 8'd0);
        chk("rst_wdata", 8'(mem_wdata), 8'd0);
        reset = 0;
        run(2'd1, 4'd0, 4'd3, 4'd0, 4'hA, 0, 0, 0);
        run(2'd0, 4'd3, 4'd0, 4'd0, 4'd0, 0, 0, 0);
        chk("load_A", 8'(load_data), 8'hA);
        run(2'd2, 4'd0, 4'd14, 4'd4, 4'd5, 0, 0, 0);
        for (int i = 0; i < 5; i++) run(2'd0, 4'(14 + i), 4'd0, 4'd0, 4'd0, 0, 0, 0);
        chk("fill_edge", 8'(load_data), 8'd0);
        run(2'd1, 4'd0, 4'd2, 4'd0, 4'd1, 0, 0, 0);
        run(2'd1, 4'd0, 4'd3, 4'd0, 4'd2, 0, 0, 0);
        run(2'd1, 4'd0, 4'd4, 4'd0, 4'd3, 0, 0, 0);
        run(2'd3, 4'd2, 4'd8, 4'd3, 4'd0, 0, 0, 0);
        for (int i = 8; i < 11; i++) run(2'd0, 4'(i), 4'd0, 4'd0, 4'd0, 0, 0, 0);
        run(2'd2, 4'd0, 4'd6, 4'd0, 4'd7, 0, 0, 0);
        run(2'd3, 4'd1, 4'd6, 4'd0, 4'd7, 0, 0, 0);
        nxt_op = 2'd0; nxt_src = 4'd7; nxt_dst = 4'd0; nxt_len = 4'd0; nxt_wd = 4'd0;
        run(2'd2, 4'd0, 4'd5, 4'd6, 4'd9, 0, 1, 1);
        run(2'd0, 4'd7, 4'd0, 4'd0, 4'd0, 1, 0, 0);
        run(2'd3, 4'd13, 4'd14, 4'd5, 4'd0, 0, 0, 0);
        @(negedge clk);
        op_i = 2'd2; dst_i = 4'd0; len_i = 4'd8; wd_i = 4'd7; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        @(negedge clk);
        chk("third_wr", 8'(mem_write), 8'd1);
        chk("third_addr", 8'(mem_address), 8'd2);
        reset = 1;
        @(negedge clk); reset = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 4'd0;
        exp_load = 4'd0;
        repeat (8) begin
            chk("abort_busy", 8'(busy), 8'd0);
            chk("abort_done", 8'(done), 8'd0);
            chk("abort_write", 8'(mem_write), 8'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 16; i++) run(2'd0, 4'(i), 4'd0, 4'd0, 4'd0, 0, 0, 0);
        pre = 0;
        c_op = 2'($urandom); c_src = 4'($urandom); c_dst = 4'($urandom); c_len = 4'($urandom); c_wd = 4'($urandom);
        for (int it = 0; it < 60; it++) begin
            nxt_op = 2'($urandom); nxt_src = 4'($urandom); nxt_dst = 4'($urandom);
            nxt_len = 4'($urandom); nxt_wd = 4'($urandom);
            ch = (it < 59) && ($urandom_range(0, 1) == 1);
            run(c_op, c_src, c_dst, c_len, c_wd, pre, ch, 0);
            pre = ch;
            c_op = nxt_op; c_src = nxt_src; c_dst = nxt_dst; c_len = nxt_len; c_wd = nxt_wd;
        end
        for (int i = 0; i < 16; i++) run(2'd0, 4'(i), 4'd0, 4'd0, 4'd0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_seq_engine.md
Name: mem_seq_engine

Overview:
- Initiator/master for the 4-bit, 16-entry data memory port.
- Drives address, write and write data on that port, and samples its combinational read data.
- Executes single load, single store, block fill and block copy operations on behalf of the core/controller via a start/busy/done handshake.
- Sits between the control FSM and data memory; the memory needs no changes.

Parameters:
- ADDR_W, 4, memory address width (16 entries); addresses wrap modulo 2^ADDR_W
- DATA_W, 4, nibble data width

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high; one clock; applied to the same edge as the data memory reset
- start  input  1  request strobe, sampled only while busy=0
- op  input  2  00 LOAD, 01 STORE, 10 FILL, 11 COPY
- src_addr  input  ADDR_W  source address (LOAD, COPY)
- dst_addr  input  ADDR_W  destination address (STORE, FILL, COPY)
- length  input  ADDR_W  element count for FILL/COPY, 0..15; ignored for LOAD/STORE
- wr_data  input  DATA_W  store/fill value
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- load_data  output  DATA_W  last nibble read by LOAD; held until next LOAD
- mem_address  output  ADDR_W  to memory address
- mem_write  output  1  to memory write
- mem_wdata  output  DATA_W  to memory data_in
- mem_rdata  input  DATA_W  from memory data_out (combinational; reads 0 while mem_write=1)

Behaviour:
- States: IDLE, RD, WR, FIN. Outputs are decoded from registered state/regs, so they are glitch-free per cycle.
- Reset (sync): state=IDLE; busy=0, done=0, load_data=0, mem_address=0, mem_write=0, mem_wdata=0, index=0.
- Reset mid-operation aborts with no further writes. The memory is also cleared by the same reset.
- IDLE/FIN outputs: mem_write=0, mem_address=0, mem_wdata=0.
- Start acceptance:
  - On a posedge with start=1 in IDLE or FIN, latch op, src_addr, dst_addr, length and wr_data, and clear index.
  - start while busy=1 is ignored (no queuing).
- First state after acceptance:
  - LOAD -> RD.
  - STORE -> WR.
  - FILL -> WR if length!=0, else FIN.
  - COPY -> RD if length!=0, else FIN.
- busy=1 exactly in RD and WR.
- RD:
  - mem_address = src+index, mem_write=0.
  - At the clock edge, mem_rdata is captured into a hold register; for LOAD it is also captured into load_data.
  - LOAD -> FIN. COPY -> WR.
- WR:
  - mem_address = dst+index, mem_write=1.
  - mem_wdata = wr_data (STORE/FILL) or the hold register (COPY).
  - After WR, index increments.
  - STORE -> FIN.
  - FILL/COPY: FIN when index+1==length, else FILL -> WR, COPY -> RD.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE unless a new start is accepted in the same cycle (back-to-back allowed).
- Address arithmetic: src+index and dst+index are truncated to ADDR_W, so they wrap 15->0.
- Latency from the start edge to done high:
  - LOAD: 2 cycles.
  - STORE: 2 cycles.
  - FILL with length L: L+1 cycles.
  - COPY with length L: 2L+1 cycles.
  - length=0: 1 cycle.
- Overlapping COPY regions are processed in ascending index order with no overlap correction.
  - Example: dst=src+1 replicates mem[src] across the region.
- Latched operands make input changes during busy irrelevant.

Optional Feature:
- Macro: MEM_SEQ_CHECKSUM_EN.
- When defined, an extra output checksum [DATA_W-1:0]:
  - Cleared to 0 on reset and on each accepted start.
  - On every WR cycle, checksum <= checksum + mem_wdata (mod 16).
  - Valid and stable from the done cycle until the next accepted start.
- When undefined, the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then STORE dst=3, wr_data=0xA: one WR cycle with mem_address=3, mem_write=1, mem_wdata=0xA; done 2 cycles after start. Then LOAD src=3: load_data=0xA, done 2 cycles after start.
- FILL dst=14, length=4, wr_data=0x5: writes to addresses 14,15,0,1 (wrap) on consecutive cycles; done at start+5; LOADs of addresses 14,15,0,1 return 5 each and address 2 returns 0.
- Preload mem[2..4]={1,2,3}, COPY src=2, dst=8, length=3: address sequence 2R,8W,3R,9W,4R,10W; mem[8..10]={1,2,3}; done at start+7; checksum=6 when MEM_SEQ_CHECKSUM_EN is defined.
- FILL and COPY with length=0: no mem_write pulses; done at start+1; busy never asserted.
- start pulsed during busy of a FILL with length=6 (different operands): ignored, and the original fill completes unchanged. A start asserted in the FIN cycle is accepted, giving back-to-back operation.
- Assert reset in the 3rd WR cycle of FILL length=8: from the next cycle busy=0, done=0, mem_write=0; no done pulse; memory reads back all zeros.
